oa_writer: RTL

OA_WRITER -- requirements
Module: oa_writer

---
 rtl/dsa_pkg.sv | 25 ++
 rtl/oa_word_fifo.sv | 60 ++++++
 rtl/oa_writer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/dsa_pkg.sv
// Shared definitions for the DSA output-activation path: ICB widths,
// writer FSM state encoding and the partial-word lane mask helper.
package dsa_pkg;

   localparam int ICB_DATA_W = 32;
   localparam int ICB_MASK_W = ICB_DATA_W / 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_REQ,
      ST_CMD,
      ST_RSP,
      ST_FINISH
   } oa_state_e;

   // Byte enables for a word whose highest filled lane is last_lane.
   function automatic logic [ICB_MASK_W-1:0] lane_mask(input logic [1:0] last_lane);
      lane_mask = '0;
      for (int i = 0; i < ICB_MASK_W; i++) begin
         lane_mask[i] = (i <= int'(last_lane));
      end
   endfunction

endpackage

// File: rtl/oa_word_fifo.sv
// Synchronous word buffer between the byte packer and the ICB burst engine.
// Holds packed wdata plus its byte mask; read data is the current head.
module oa_word_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 36
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_en,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_wr;
   logic             w_do_rd;

   assign w_do_wr = i_wr_en && !o_full;
   assign w_do_rd = i_rd_en && !o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the storage array is reset too, so the head word is a known 0 after reset.
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_do_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;

endmodule

// File: rtl/oa_writer.sv
// Output-activation writer: packs int8 results into 32-bit words and writes
// them to memory over ICB in arbitrated bursts. Optional OA_WRITER_ERR_CNT_EN
// adds a saturating err_count of error responses.
module oa_writer
   import dsa_pkg::*;
#(
   parameter int BUS_WIDTH   = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int BURST_WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   init_cfg_oa,
   input  logic [ADDR_WIDTH-1:0]  cfg_oa_base_addr,
   input  logic [31:0]            cfg_oa_total,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic                   write_oa_req,
   input  logic                   write_oa_granted,
   output logic                   write_done,
   output logic                   oa_calc_over,
   output logic                   icb_cmd_valid,
   input  logic                   icb_cmd_ready,
   output logic [ADDR_WIDTH-1:0]  icb_cmd_addr,
   output logic                   icb_cmd_read,
   output logic [BUS_WIDTH-1:0]   icb_cmd_wdata,
   output logic [BUS_WIDTH/8-1:0] icb_cmd_wmask,
   input  logic                   icb_rsp_valid,
   output logic                   icb_rsp_ready,
   input  logic                   icb_rsp_err
`ifdef OA_WRITER_ERR_CNT_EN
   ,
   output logic [15:0]            err_count
`endif
);

   localparam int CNT_W  = $clog2(BURST_WORDS) + 1;
   localparam int FIFO_W = ICB_DATA_W + ICB_MASK_W;

   oa_state_e               r_state;
   oa_state_e               w_next_state;
   logic [ADDR_WIDTH-1:0]   r_base;
   logic [ADDR_WIDTH-1:0]   r_word_idx;
   logic [31:0]             r_bytes_left;
   logic [31:0]             r_words_left;
   logic [1:0]              r_lane;
   logic [ICB_DATA_W-1:0]   r_pack;
   logic                    r_push;
   logic [FIFO_W-1:0]       r_push_word;
   logic [CNT_W-1:0]        r_burst_left;

   logic                    w_accept;
   logic                    w_word_done;
   logic                    w_cmd_fire;
   logic                    w_init_ok;
   logic                    w_room;
   logic [ICB_DATA_W-1:0]   w_pack_next;
   logic [31:0]             w_total_words;
   logic [FIFO_W-1:0]       w_head;
   logic [CNT_W-1:0]        w_count;
   logic                    w_fifo_full;
   logic                    w_fifo_empty;

   assign w_accept      = in_valid && in_ready;
   assign w_word_done   = w_accept && ((r_lane == 2'd3) || (r_bytes_left == 32'd1));
   assign w_cmd_fire    = icb_cmd_valid && icb_cmd_ready;
   assign w_init_ok     = init_cfg_oa && ((r_state == ST_IDLE) || (r_state == ST_FINISH));
   assign w_pack_next   = r_pack | (ICB_DATA_W'(in_data) << {r_lane, 3'b000});
   assign w_total_words = 32'(({1'b0, cfg_oa_total} + 33'd3) >> 2);
   // A word already in flight to the buffer counts as occupying a slot.
   assign w_room        = (w_count + CNT_W'(r_push)) < CNT_W'(BURST_WORDS);

   oa_word_fifo #(
      .DEPTH (BURST_WORDS),
      .WIDTH (FIFO_W)
   ) u_word_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (r_push),
      .i_wr_data (r_push_word),
      .i_rd_en   (w_cmd_fire),
      .o_rd_data (w_head),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty),
      .o_count   (w_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state <= w_next_state;
      end
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
      w_next_state = r_state;
      case (r_state)
         ST_IDLE, ST_FINISH: begin
            if (init_cfg_oa) begin
               w_next_state = (cfg_oa_total == 32'd0) ? ST_FINISH : ST_FILL;
            end
         end
         ST_FILL: begin
            if ((w_count >= CNT_W'(BURST_WORDS)) ||
                ((w_count != '0) && (r_bytes_left == 32'd0) && !r_push)) begin
               w_next_state = ST_REQ;
            end
         end
         ST_REQ: begin
            if (write_oa_granted) w_next_state = ST_CMD;
         end
         ST_CMD: begin
            if (w_cmd_fire) w_next_state = ST_RSP;
         end
         ST_RSP: begin
            if (icb_rsp_valid) begin
               if (r_burst_left != '0)        w_next_state = ST_CMD;
               else if (r_words_left == 32'd0) w_next_state = ST_FINISH;
               else                            w_next_state = ST_FILL;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready      = 1'b0;
      write_oa_req  = 1'b0;
      icb_cmd_valid = 1'b0;
      write_done    = 1'b0;
      oa_calc_over  = 1'b0;
      case (r_state)
         ST_FILL: in_ready = (r_bytes_left != 32'd0) && w_room;
         ST_REQ, ST_CMD, ST_RSP: begin
            in_ready      = (r_bytes_left != 32'd0) && w_room;
            write_oa_req  = 1'b1;
            icb_cmd_valid = (r_state == ST_CMD);
            write_done    = (r_state == ST_RSP) && icb_rsp_valid && (r_burst_left == '0);
         end
         ST_FINISH: oa_calc_over = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base       <= '0;
         r_word_idx   <= '0;
         r_bytes_left <= '0;
         r_words_left <= '0;
         r_lane       <= '0;
         r_pack       <= '0;
         r_push       <= 1'b0;
         r_push_word  <= '0;
         r_burst_left <= '0;
      end else if (w_init_ok) begin
         r_base       <= cfg_oa_base_addr;
         r_word_idx   <= '0;
         r_bytes_left <= cfg_oa_total;
         r_words_left <= w_total_words;
         r_lane       <= '0;
         r_pack       <= '0;
         r_push       <= 1'b0;
      end else begin
         r_push <= w_word_done;
         if (w_word_done) begin
            r_push_word <= {lane_mask(r_lane), w_pack_next};
         end
         if (w_accept) begin
            r_bytes_left <= r_bytes_left - 32'd1;
            r_lane       <= w_word_done ? 2'd0 : r_lane + 2'd1;
            r_pack       <= w_word_done ? '0 : w_pack_next;
         end
         // Burst length is whatever the buffer holds when the request goes out.
         if ((r_state == ST_FILL) && (w_next_state == ST_REQ)) begin
            r_burst_left <= w_count;
         end else if (w_cmd_fire) begin
            r_burst_left <= r_burst_left - CNT_W'(1);
         end
         if (w_cmd_fire) begin
            r_word_idx   <= r_word_idx + ADDR_WIDTH'(1);
            r_words_left <= r_words_left - 32'd1;
         end
      end
   end

   assign icb_cmd_addr  = r_base + (r_word_idx << 2);
   assign icb_cmd_wdata = w_head[ICB_DATA_W-1:0];
   assign icb_cmd_wmask = w_head[FIFO_W-1:ICB_DATA_W];
   assign icb_cmd_read  = 1'b0;
   assign icb_rsp_ready = 1'b1;

`ifdef OA_WRITER_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (w_init_ok) begin
         err_count <= '0;
      end else if (icb_rsp_valid && icb_rsp_err && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
   logic w_unused;
   assign w_unused = w_fifo_full ^ w_fifo_empty;
`else
   logic w_unused;
   assign w_unused = icb_rsp_err ^ w_fifo_full ^ w_fifo_empty;
`endif

endmodule
